// File: rtl/dds_reset_sequencer.sv
// rtl/dds_reset_sequencer.sv - timed, phase-aligned reset pulse sequencer for two DDS channels
//
// Memory-mapped slave that asserts the selected DDS channel resets for a
// programmable hold time. It then waits a programmable settle time and
// flags completion, optionally raising a level interrupt.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   address     register select (0 CTRL, 1 HOLD, 2 SETTLE, 3 STATUS)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data, zero wait states
//   dds_reset   per-channel DDS reset, bit0 = channel A
//   irq         completion interrupt, done & irq_en
module dds_reset_sequencer #(
    parameter int CNT_W      = 16,
    parameter int DEF_HOLD   = 4,
    parameter int DEF_SETTLE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  dds_reset,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [1:0]       mask_q;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] settle_q;
    logic [CNT_W-1:0] settle_snap;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             irq_en_q;

    logic wr_en;
    logic go_req;
    logic busy;
    logic unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign go_req       = wr_en && (address == 2'd0) && writedata[2] && (writedata[1:0] != 2'b00);
    assign busy         = (state != ST_IDLE);
    assign irq          = done_q & irq_en_q;
    assign unused_wdata = ^writedata[31:CNT_W];

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {30'd0, mask_q};
            2'd1:    readdata = 32'(hold_q);
            2'd2:    readdata = 32'(settle_q);
            default: readdata = {29'd0, irq_en_q, done_q, busy};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mask_q      <= 2'b00;
            hold_q      <= CNT_W'(DEF_HOLD);
            settle_q    <= CNT_W'(DEF_SETTLE);
            settle_snap <= '0;
            cnt         <= '0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            dds_reset   <= 2'b00;
        end else begin
            if (wr_en && address == 2'd1)
                hold_q <= writedata[CNT_W-1:0];
            if (wr_en && address == 2'd2)
                settle_q <= writedata[CNT_W-1:0];
            if (wr_en && address == 2'd3) begin
                irq_en_q <= writedata[2];
                if (writedata[1])
                    done_q <= 1'b0;
            end

            // Completion assignments to done_q come after the W1C clear
            // above, so a set on the same edge overrides the clear.
            case (state)
                ST_IDLE: begin
                    if (go_req) begin
                        state       <= ST_HOLD;
                        mask_q      <= writedata[1:0];
                        dds_reset   <= writedata[1:0];
                        cnt         <= (hold_q == '0) ? CNT_ONE : hold_q;
                        settle_snap <= settle_q;
                    end
                end
                ST_HOLD: begin
                    if (cnt == CNT_ONE) begin
                        dds_reset <= 2'b00;
                        if (settle_snap != '0) begin
                            state <= ST_SETTLE;
                            cnt   <= settle_snap;
                        end else begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_ONE) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    dds_reset <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_reset_sequencer.sv
// tb/tb_dds_reset_sequencer.sv - scoreboard bench for dds_reset_sequencer
module tb_dds_reset_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  dds_reset;
    logic        irq;

    dds_reset_sequencer #(.CNT_W(16), .DEF_HOLD(4), .DEF_SETTLE(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .dds_reset  (dds_reset),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         t;
        logic [1:0] mask;
        int         h;
        int         e;
    } pulse_t;

    typedef struct {
        logic [31:0] data;
        logic        irq;
    } rd_t;

    pulse_t pq[$];
    rd_t    rq[$];
    bit     rd_pending = 0;

    // Reference model: a sequence is a time window [t, e]; done appears at edge e.
    int         m_hold, m_settle, m_end;
    bit         m_done, m_irq_en, m_active;
    logic [1:0] m_lastmask;

    function automatic void model_reset();
        m_hold = 4; m_settle = 8; m_end = 0;
        m_done = 0; m_irq_en = 0; m_active = 0; m_lastmask = 2'b00;
    endfunction

    function automatic void model_advance(input int c);
        if (m_active && m_end <= c) begin
            m_done   = 1;
            m_active = 0;
        end
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        int e;
        pulse_t p;
        @(negedge clk);
        e = cyc + 1;
        model_advance(e - 1);
        case (a)
            2'd0: if (d[2] && d[1:0] != 2'b00 && !m_active) begin
                p.t  = e;
                p.mask = d[1:0];
                p.h  = (m_hold == 0) ? 1 : m_hold;
                p.e  = e + p.h + m_settle;
                m_lastmask = d[1:0];
                m_active = 1;
                m_end = p.e;
                pq.push_back(p);
            end
            2'd1: m_hold = int'(d[15:0]);
            2'd2: m_settle = int'(d[15:0]);
            default: begin
                m_irq_en = d[2];
                if (d[1]) m_done = 0;
            end
        endcase
        model_advance(e);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd3; writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        rd_t r;
        @(posedge clk);
        #1;
        model_advance(cyc);
        case (a)
            2'd0:    r.data = {30'd0, m_lastmask};
            2'd1:    r.data = 32'(m_hold);
            2'd2:    r.data = 32'(m_settle);
            default: r.data = {29'd0, m_irq_en, m_done, m_active};
        endcase
        r.irq = m_done & m_irq_en;
        rq.push_back(r);
        address = a;
        rd_pending = 1;
        @(negedge clk);
        #1;
        rd_pending = 0;
        address = 2'd3;
    endtask

    task automatic wait_done();
        if (m_active)
            while (cyc < m_end) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("dds_reset async clear", {30'd0, dds_reset}, 32'd0);
        check("irq in reset", {31'd0, irq}, 32'd0);
        model_reset();
        pq.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: pops read expectations and pulse records as the DUT presents them.
    bit     in_pulse = 0;
    bit     wait_end = 0;
    pulse_t cur;
    int     plen;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_pulse = 0;
                wait_end = 0;
            end else begin
                if (rd_pending) begin
                    if (rq.size() == 0) begin
                        check("read queue empty", 32'd1, 32'd0);
                    end else begin
                        rd_t r;
                        r = rq.pop_front();
                        check("readdata", readdata, r.data);
                        check("irq", {31'd0, irq}, {31'd0, r.irq});
                    end
                end
                if (!in_pulse && dds_reset != 2'b00) begin
                    if (pq.size() == 0) begin
                        check("unexpected pulse", {30'd0, dds_reset}, 32'd0);
                    end else begin
                        cur = pq.pop_front();
                        check("pulse start cycle", cyc, cur.t);
                        check("pulse mask", {30'd0, dds_reset}, {30'd0, cur.mask});
                        in_pulse = 1;
                        plen = 1;
                    end
                end else if (in_pulse && dds_reset != 2'b00) begin
                    plen++;
                    if (dds_reset != cur.mask)
                        check("pulse mask stable", {30'd0, dds_reset}, {30'd0, cur.mask});
                end else if (in_pulse) begin
                    in_pulse = 0;
                    check("pulse length", plen, cur.h);
                    wait_end = 1;
                end
                if (wait_end && address == 2'd3 && !readdata[0]) begin
                    wait_end = 0;
                    check("busy end cycle", cyc, cur.e);
                    check("done at end", {31'd0, readdata[1]}, 32'd1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] msk;
        int h, s;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd3; writedata = 32'd0;
        @(posedge clk);
        apply_reset();

        // Reset defaults
        bus_read(2'd1);
        bus_read(2'd2);
        bus_read(2'd3);
        bus_read(2'd0);

        // Basic pulse
        bus_write(2'd1, 32'd3);
        bus_write(2'd2, 32'd5);
        bus_write(2'd0, 32'h7);
        wait_done();
        bus_read(2'd3);

        // Zero hold and settle
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h5);
        wait_done();
        bus_read(2'd1);
        bus_read(2'd3);

        // Ignored go with mask 0, then go during HOLD
        bus_write(2'd3, 32'h2);
        bus_write(2'd0, 32'h4);
        bus_read(2'd3);
        bus_write(2'd1, 32'd6);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h7);
        bus_write(2'd0, 32'h6);
        bus_read(2'd0);
        wait_done();
        bus_read(2'd0);

        // IRQ and W1C
        bus_write(2'd3, 32'h6);
        bus_read(2'd3);
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'h5);
        wait_done();
        bus_read(2'd3);
        bus_write(2'd3, 32'h6);
        bus_read(2'd3);

        // Clear on the completion edge
        bus_write(2'd0, 32'h6);
        @(negedge clk);
        while (cyc < m_end - 2) @(negedge clk);
        bus_write(2'd3, 32'h6);
        bus_read(2'd3);

        // Randomized sequences
        for (int i = 0; i < 24; i++) begin
            h   = $urandom_range(0, 7);
            s   = $urandom_range(0, 7);
            msk = 2'($urandom_range(0, 3));
            bus_write(2'd1, 32'(h));
            bus_write(2'd2, 32'(s));
            bus_write(2'd3, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0});
            bus_write(2'd0, {29'd0, 1'b1, msk});
            if ($urandom_range(0, 1) == 1)
                bus_write(2'd0, {29'd0, 1'b1, 2'($urandom_range(0, 3))});
            if ($urandom_range(0, 1) == 1)
                bus_write(2'd1, 32'($urandom_range(0, 7)));
            wait_done();
            bus_read(2'($urandom_range(0, 3)));
            bus_read(2'd3);
        end

        // Reset mid-HOLD
        bus_write(2'd3, 32'h4);
        bus_write(2'd1, 32'd10);
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, 32'h7);
        repeat (3) @(negedge clk);
        apply_reset();
        bus_read(2'd1);
        bus_read(2'd2);
        bus_read(2'd3);
        bus_read(2'd0);
        repeat (20) @(negedge clk);

        check("pulse queue drained", pq.size(), 32'd0);
        check("read queue drained", rq.size(), 32'd0);
        check("monitor idle", {30'd0, in_pulse, wait_end}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
